// File: rtl/peripheral_mpram_wb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// peripheral_mpram_wb_pkg: Wishbone cycle/burst type codes and slave FSM states
// rev 1.0
// ----------------------------------------------------------------------------
package peripheral_mpram_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CLASSIC = 2'd1;
  localparam state_t ST_BURST   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/peripheral_mpram_wb_burst_adr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// peripheral_mpram_wb_burst_adr: next beat word address for linear/wrap bursts
// rev 1.0
// ----------------------------------------------------------------------------
module peripheral_mpram_wb_burst_adr
  import peripheral_mpram_wb_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [AW-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [AW-1:0] nxt_adr_o
);

  logic [AW-1:0] inc_adr;
  logic [AW-1:0] wrap_mask;

  // Only the bits under wrap_mask count; the rest stay at the aligned block base.
  always_comb begin
    inc_adr = adr_i + AW'(1);
    case (bte_i)
      BTE_LINEAR: wrap_mask = '1;
      BTE_WRAP4:  wrap_mask = AW'(3);
      BTE_WRAP8:  wrap_mask = AW'(7);
      BTE_WRAP16: wrap_mask = AW'(15);
      default:    wrap_mask = '1;
    endcase
    nxt_adr_o = (adr_i & ~wrap_mask) | (inc_adr & wrap_mask);
  end

endmodule

`default_nettype wire

// File: rtl/peripheral_mpram_wb_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// peripheral_mpram_wb_slave: Wishbone B3 classic/burst slave for a byte-enable RAM
// rev 1.0
// ----------------------------------------------------------------------------
module peripheral_mpram_wb_slave
  import peripheral_mpram_wb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [3:0]    ram_we,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [AW-1:0] burst_adr_q, burst_adr_d;

  logic          req;
  logic          resp_ok;
  logic [29:0]   word_idx;
  logic [AW-1:0] cur_adr;
  logic [AW-1:0] nxt_adr;
  logic          cur_bad;
  logic          nxt_bad;
  logic          unused_adr_bits;

  assign req             = wb_cyc_i & wb_stb_i;
  assign word_idx        = wb_adr_i[31:2];
  assign cur_adr         = wb_adr_i[AW+1:2];
  assign cur_bad         = ({2'b00, word_idx} >= DEPTH_U);
  assign nxt_bad         = ({{(32-AW){1'b0}}, nxt_adr} >= DEPTH_U);
  assign unused_adr_bits = &{1'b0, wb_adr_i[1:0]};

  peripheral_mpram_wb_burst_adr #(
    .AW (AW)
  ) u_burst_adr (
    .adr_i     (burst_adr_q),
    .bte_i     (wb_bte_i),
    .nxt_adr_o (nxt_adr)
  );

  // In BURST the current beat is always being acked, so the decision made here
  // is whether the following beat gets acked too.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    burst_adr_d = burst_adr_q;
    if (!req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cur_bad) begin
            err_d   = 1'b1;
            state_d = ST_CLASSIC;
          end else begin
            ack_d = 1'b1;
            case (wb_cti_i)
              CTI_INCR: begin
                state_d     = ST_BURST;
                burst_adr_d = cur_adr;
              end
              CTI_CLASSIC, CTI_CONST, CTI_END: state_d = ST_CLASSIC;
              default:                         state_d = ST_CLASSIC;
            endcase
          end
        end
        ST_BURST: begin
          if (wb_cti_i != CTI_INCR) begin
            state_d = ST_IDLE;
          end else if (nxt_bad) begin
            // CLASSIC holds off re-acceptance while the master sees the error.
            err_d   = 1'b1;
            state_d = ST_CLASSIC;
          end else begin
            ack_d       = 1'b1;
            burst_adr_d = nxt_adr;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      burst_adr_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      burst_adr_q <= burst_adr_d;
    end
  end

  // Responses die immediately when reset is applied, so an aborted beat never writes.
  assign resp_ok   = req & rst_n;
  assign wb_ack_o  = ack_q & resp_ok;
  assign wb_err_o  = err_q & resp_ok;
  assign ram_we    = (wb_ack_o & wb_we_i) ? wb_sel_i : 4'b0000;
  assign ram_din   = wb_dat_i;
  assign ram_waddr = (state_q == ST_BURST) ? burst_adr_q : cur_adr;
  assign ram_raddr = (state_q == ST_BURST) ? nxt_adr : cur_adr;
  assign wb_dat_o  = ram_dout;

endmodule

`default_nettype wire
